// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU operand sequencer:
//               FSM state encoding, operand width and the default
//               debounce interval.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Width of each ALU operand taken from the slide switches
    localparam int c_OPERAND_W = 4;

    // Stable cycles needed to accept a button level change (10 ms at 50 MHz)
    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Sequencer states; the codes drive the board LEDs directly.
    // 2'b11 is never entered and falls back to WAIT_A.
    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        HOLD   = 2'b10
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronizes a raw push button, debounces it with a
//               consecutive-stable-cycle counter and emits a one-cycle
//               press pulse on each accepted 0->1 transition.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    // The counter only ever reaches DEBOUNCE_CYCLES-1: on that cycle the
    // level flips and the counter clears instead of incrementing.
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               meta_q,  meta_d;
    logic               sync_q,  sync_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state: two-flop synchronizer, then count cycles of disagreement
    always_comb begin
        meta_d  = btn;
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == c_CNT_LAST) begin
                level_d = ~level_q;
                // Only a rising debounced edge counts as a press
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_input_sequencer
// Description : Captures two 4-bit ALU operands from slide switches using a
//               single debounced push button: press 1 latches A, press 2
//               latches B and raises operands_valid, press 3 clears both.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [c_OPERAND_W-1:0] sw,
    input  logic                   btn,
    output logic [c_OPERAND_W-1:0] a,
    output logic [c_OPERAND_W-1:0] b,
    output logic                   operands_valid,
    output logic [1:0]             state
);

    logic                   press;
    logic [c_OPERAND_W-1:0] sw_meta_q, sw_meta_d;
    logic [c_OPERAND_W-1:0] sw_sync_q, sw_sync_d;
    logic [c_OPERAND_W-1:0] a_q,       a_d;
    logic [c_OPERAND_W-1:0] b_q,       b_d;
    logic                   valid_q,   valid_d;
    alu_state_t             state_q,   state_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press)
    );

    // Next-state: switch synchronizer and press-driven operand sequencing
    always_comb begin
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
        a_d       = a_q;
        b_d       = b_q;
        valid_d   = valid_q;
        state_d   = state_q;
        case (state_q)
            WAIT_A: begin
                if (press) begin
                    a_d     = sw_sync_q;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press) begin
                    b_d     = sw_sync_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (press) begin
                    a_d     = '0;
                    b_d     = '0;
                    valid_d = 1'b0;
                    state_d = WAIT_A;
                end
            end
            default: begin
                // Illegal code: return to a clean WAIT_A so valid tracks HOLD
                a_d     = '0;
                b_d     = '0;
                valid_d = 1'b0;
                state_d = WAIT_A;
            end
        endcase
    end

    // State and operand registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            valid_q   <= 1'b0;
            state_q   <= WAIT_A;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            a_q       <= a_d;
            b_q       <= b_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign operands_valid = valid_q;
    assign state          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_input_sequencer
// Description : Self-checking bench for alu_input_sequencer with a short
//               debounce interval, comparing against a sampled-history model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_input_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [3:0] sw;
    logic [3:0] a;
    logic [3:0] b;
    logic       operands_valid;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: history of raw samples taken at each rising edge
    logic       btn_h[$];
    logic [3:0] sw_h[$];
    logic [1:0] m_state;
    logic [3:0] m_a, m_b;
    logic       m_valid, m_level, m_pend;
    int         m_last;

    alu_input_sequencer #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw             (sw),
        .btn            (btn),
        .a              (a),
        .b              (b),
        .operands_valid (operands_valid),
        .state          (state)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_state = 2'd0;
        m_a     = 4'h0;
        m_b     = 4'h0;
        m_valid = 1'b0;
        m_level = 1'b0;
        m_pend  = 1'b0;
        m_last  = btn_h.size() - 1;
    endfunction

    // Level flips once N consecutive synchronized samples (two edges old)
    // disagree with it since the last flip; a rising flip is a press that
    // captures the switch value seen two edges earlier on the next edge.
    function automatic void model_step();
        int e;
        bit tog;
        btn_h.push_back(rst_n ? btn : 1'b0);
        sw_h.push_back(rst_n ? sw : 4'h0);
        e = btn_h.size() - 1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_pend) begin
            m_pend = 1'b0;
            case (m_state)
                2'd0:    begin m_a = sw_h[e-2]; m_state = 2'd1; end
                2'd1:    begin m_b = sw_h[e-2]; m_valid = 1'b1; m_state = 2'd2; end
                default: begin m_a = 4'h0; m_b = 4'h0; m_valid = 1'b0; m_state = 2'd0; end
            endcase
        end
        tog = (e - m_last >= N);
        for (int j = e - N + 1; j <= e; j++)
            if (j < 2 || btn_h[j-2] == m_level) tog = 1'b0;
        if (tog) begin
            m_level = ~m_level;
            m_last  = e;
            if (m_level) m_pend = 1'b1;
        end
    endfunction

    // Drive one cycle of stimulus from a falling edge to the next one
    task automatic cyc(input logic b_in, input logic [3:0] s_in);
        btn = b_in;
        sw  = s_in;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] s_in, input int hi, input int lo);
        for (int i = 0; i < hi; i++) cyc(1'b1, s_in);
        for (int i = 0; i < lo; i++) cyc(1'b0, s_in);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 1'b0;
        sw    = 4'h0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'hF);
        checks++;
        if ({a, b, operands_valid, state} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got a=%h b=%h v=%b st=%b, want all zero", a, b, operands_valid, state);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) cyc(1'b0, 4'h0);
        checks++;
        if ({a, b, operands_valid, state} !== 11'd0) begin
            errors++;
            $display("FAIL reset_release: got a=%h b=%h v=%b st=%b, want all zero", a, b, operands_valid, state);
        end
    endtask

    task automatic test_clean_sequence();
        pulse(4'hA, N + 3, N + 3);
        pulse(4'h5, N + 3, N + 3);
        checks++;
        if (a !== 4'hA || b !== 4'h5 || operands_valid !== 1'b1 || state !== 2'b10) begin
            errors++;
            $display("FAIL clean_seq: got a=%h b=%h v=%b st=%b, want a=a b=5 v=1 st=10", a, b, operands_valid, state);
        end
        checks++;
        if ({a, b, operands_valid, state} !== {m_a, m_b, m_valid, m_state}) begin
            errors++;
            $display("FAIL clean_seq_model: got a=%h b=%h v=%b st=%b, want a=%h b=%h v=%b st=%b",
                     a, b, operands_valid, state, m_a, m_b, m_valid, m_state);
        end
    endtask

    task automatic test_third_press();
        pulse(4'hF, N + 3, N + 3);
        checks++;
        if (a !== 4'h0 || b !== 4'h0 || operands_valid !== 1'b0 || state !== 2'b00) begin
            errors++;
            $display("FAIL third_press: got a=%h b=%h v=%b st=%b, want all zero", a, b, operands_valid, state);
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                cyc(i < 3, 4'($urandom_range(1, 15)));
                checks++;
                if (state !== 2'b00 || a !== 4'h0 || state !== m_state) begin
                    errors++;
                    $display("FAIL bounce r%0d c%0d: got st=%b a=%h, want st=00 a=0 (model st=%b)", r, i, state, a, m_state);
                end
            end
        end
        for (int i = 0; i < N + 2; i++) cyc(1'b0, 4'h0);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL bounce_final: got st=%b, want 00", state);
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h9);
        // First high sample is edge k (i=0); capture must land at edge k+6
        for (int i = 0; i <= 7; i++) begin
            logic [3:0] want;
            cyc(1'b1, 4'h9);
            want = (i >= N + 2) ? 4'h9 : 4'h0;
            checks++;
            if (a !== want) begin
                errors++;
                $display("FAIL latency edge k+%0d: got a=%h, want %h", i, a, want);
            end
        end
        for (int i = 0; i < N + 3; i++) cyc(1'b0, 4'h9);
        checks++;
        if (state !== 2'b01 || state !== m_state) begin
            errors++;
            $display("FAIL latency_state: got st=%b, want 01 (model %b)", state, m_state);
        end
    endtask

    task automatic test_hold_long();
        int transitions;
        logic [1:0] prev;
        pulse(4'h7, N + 3, N + 3);
        pulse(4'h0, N + 3, N + 3);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL hold_setup: got st=%b, want 00", state);
        end
        transitions = 0;
        prev = state;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 4'h3);
            if (state !== prev) transitions++;
            prev = state;
            checks++;
            if ({a, b, operands_valid, state} !== {m_a, m_b, m_valid, m_state}) begin
                errors++;
                $display("FAIL hold_long c%0d: got a=%h st=%b, want a=%h st=%b", i, a, state, m_a, m_state);
            end
        end
        checks++;
        if (transitions != 1 || state !== 2'b01 || a !== 4'h3) begin
            errors++;
            $display("FAIL hold_long_once: got %0d captures st=%b a=%h, want 1 capture st=01 a=3", transitions, state, a);
        end
    endtask

    task automatic test_async_reset();
        btn = 1'b1;
        sw  = 4'h3;
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (a !== 4'h0 || state !== 2'b00 || operands_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got a=%h st=%b v=%b before next edge, want a=0 st=00 v=0", a, state, operands_valid);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h6);
        rst_n = 1'b1;
        // Button still held: exactly one press once it re-debounces
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 4'h6);
            checks++;
            if ({a, b, operands_valid, state} !== {m_a, m_b, m_valid, m_state}) begin
                errors++;
                $display("FAIL post_reset c%0d: got a=%h st=%b, want a=%h st=%b", i, a, state, m_a, m_state);
            end
        end
        checks++;
        if (state !== 2'b01 || a !== 4'h6) begin
            errors++;
            $display("FAIL post_reset_press: got st=%b a=%h, want st=01 a=6", state, a);
        end
        for (int i = 0; i < N + 4; i++) cyc(1'b0, 4'h0);
    endtask

    task automatic test_random();
        logic lvl;
        lvl = 1'b0;
        for (int r = 0; r < 40; r++) begin
            int len;
            logic [3:0] s;
            lvl = ~lvl;
            len = $urandom_range(1, 8);
            s   = 4'($urandom_range(0, 15));
            for (int i = 0; i < len; i++) begin
                cyc(lvl, s);
                checks++;
                if ({a, b, operands_valid, state} !== {m_a, m_b, m_valid, m_state} ||
                    operands_valid !== (state == 2'b10)) begin
                    errors++;
                    $display("FAIL random r%0d c%0d: got a=%h b=%h v=%b st=%b, want a=%h b=%h v=%b st=%b",
                             r, i, a, b, operands_valid, state, m_a, m_b, m_valid, m_state);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_sequence();
        test_third_press();
        test_bounce();
        test_latency();
        test_hold_long();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
